baud_tick_generator: RTL and testbench
======================================

Name: baud_tick_generator

Overview:
Programmable successor to the fixed UART divider. It emits single-cycle enable ticks, not divided clocks, so all UART logic stays on `clk`.
- Divisor is runtime-loadable, with a fractional accumulator for low baud error.
- Oversample ratio is parametrised.
- The rx tick phase can be restarted on a start-bit edge.
- Sits between the register interface (divisor load) and the uart rx/tx engines (tick consumers).

Parameters:
CLOCK_RATE, 100000000, board clock in Hz (reset-default divisor only)
BAUD_RATE, 9600, reset-default baud
OVERSAMPLE, 16, rx ticks per bit; power of two, 4..64
DIV_WIDTH, 16, integer divisor width
FRAC_WIDTH, 4, fractional divisor width

Ports:
clk  in  1  board clock
rstN  in  1  synchronous active-low reset
enable  in  1  1 = counting; 0 = freeze all state, ticks 0
divInt  in  DIV_WIDTH  integer clocks per rx tick
divFrac  in  FRAC_WIDTH  fractional part, units of 2^-FRAC_WIDTH
divLoad  in  1  one-cycle strobe: capture divInt/divFrac
divErr  out  1  one-cycle pulse: load rejected
rxRestart  in  1  one-cycle strobe: restart rx phase
rxTick  out  1  one-cycle pulse at OVERSAMPLE x baud
rxPhase  out  $clog2(OVERSAMPLE)  rx tick index within bit
rxSample  out  1  one-cycle pulse at mid-bit
txTick  out  1  one-cycle pulse at baud

Behaviour:
- Only rstN is stated here: synchronous, active-low, one clk domain. rstN low at a clk edge has priority over every other input.
- Reset values: all outputs 0; counters, accumulators and rxPhase 0; no pending load.
- Reset divisor is D = (CLOCK_RATE*2^FRAC_WIDTH)/(BAUD_RATE*OVERSAMPLE), floored. divInt = D>>FRAC_WIDTH; divFrac = low bits. Defaults give 651/0.
- Elaboration error if default divInt < 2 or it does not fit DIV_WIDTH.
- Divider path:
  - Counter increments each enabled edge.
  - When count == period-1: count <= 0 and the tick register <= 1; otherwise tick <= 0. The tick is registered.
  - period = divInt, or divInt+1 if the previous wrap's add acc+divFrac carried out of FRAC_WIDTH.
  - acc updates only at wrap, modulo 2^FRAC_WIDTH.
  - First period after reset/restart is divInt.
- Two independent divider paths share the divisor register:
  - rx path drives rxTick.
  - tx path drives an OVERSAMPLE wrap counter; txTick pulses on the edge where that counter wraps. Tx bit period is exactly OVERSAMPLE rx-equivalent periods.
- rxPhase increments on each rxTick and wraps OVERSAMPLE-1 -> 0.
- rxSample is coincident with the rxTick that sets rxPhase to OVERSAMPLE/2.
- divLoad:
  - divInt < 2: reject. divErr = 1 next cycle; old divisor kept; any earlier pending load is kept.
  - Otherwise store as pending. Each path adopts it at its own next wrap, so there are no runt periods. acc is not cleared on adopt.
  - A new divLoad overwrites an unadopted pending value.
- rxRestart:
  - Next edge: rx count, rx acc, rxPhase and rxTick <= 0; rx adopts any pending divisor immediately.
  - Tx path is unaffected.
- Simultaneous divLoad and rxRestart: rx adopts the new divisor immediately; tx adopts it at its next wrap.
- enable low: every counter/acc frozen, all tick outputs 0, pending loads still captured. Counting resumes from the frozen state.
- divErr is independent of enable.

Decomposition:
- uart_pkg holds:
  - default-divisor function
  - OVERSAMPLE legality check
  - DIV_WIDTH/FRAC_WIDTH defaults
- Sub-module baud_tick_divider contains counter, fractional accumulator, pending-adopt logic, restart input and tick output. It is instantiated twice (rx, tx).
- Top-level holds divisor capture/validation, rxPhase/rxSample and the tx OVERSAMPLE counter.

Test Plan:
- Reset, enable=1, load divInt=4 divFrac=0, OVERSAMPLE=16 -> rxTick every 4 cycles; txTick every 64 cycles; rxPhase cycles 0..15; rxSample when rxPhase becomes 8.
- divInt=4, divFrac=8 (FRAC_WIDTH=4) -> first five rx periods 4,4,5,4,5; 32 rxTicks span 144 cycles.
- Divisor changed mid-period (4 -> 10) -> current period completes at 4 cycles; next periods are 10; no short or long glitch period on rx or tx.
- divLoad with divInt=1 -> divErr pulses one cycle; tick spacing unchanged.
- rxRestart at an arbitrary cycle -> next rxTick exactly divInt cycles later with rxPhase=1; txTick spacing undisturbed.
- enable low for 7 cycles mid-period, and rstN low mid-period -> enable: periods stretch by exactly 7 with no ticks while low; rstN: all outputs 0 next edge and divisor returns to the default 651/0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud-rate logic: default divisor widths,
// the reset-default divisor computation and the oversample legality check.
package uart_pkg;

  localparam int unsigned DEF_DIV_WIDTH  = 16;
  localparam int unsigned DEF_FRAC_WIDTH = 4;

  // Floored fixed-point divisor (integer.fraction) for a clock/baud/oversample set.
  function automatic longint unsigned defaultDivisor(
    input longint unsigned clockRate,
    input longint unsigned baudRate,
    input longint unsigned oversample,
    input int unsigned     fracWidth
  );
    return (clockRate << fracWidth) / (baudRate * oversample);
  endfunction

  // Oversample ratio must be a power of two in 4..64.
  function automatic bit oversampleLegal(input int unsigned oversample);
    return (oversample >= 4) && (oversample <= 64) &&
           ((oversample & (oversample - 1)) == 0);
  endfunction

endpackage

// File: rtl/baud_tick_divider.sv
// Fractional-N tick divider: emits a one-cycle tick every divInt or divInt+1
// enabled clocks, the extra cycle inserted whenever the fractional accumulator
// carries. A new divisor is held pending and adopted only at a wrap (or at a
// restart), so no runt or stretched period is ever produced.
//
// Ports:
//   clk, rstN   clock, synchronous active-low reset
//   enable      1 = counting; 0 = freeze counter/accumulator, tick 0
//   restart     clear count/acc/tick and adopt any pending divisor now
//   adoptReq    a validated divisor load is presented this cycle
//   nextInt     divisor to adopt (incoming load, else the pending value)
//   nextFrac    fractional part of nextInt
//   tick        registered one-cycle tick
//   wrap_c      combinational: the counter wraps at this edge
module baud_tick_divider #(
  parameter int unsigned           DIV_WIDTH  = 16,
  parameter int unsigned           FRAC_WIDTH = 4,
  parameter logic [DIV_WIDTH-1:0]  RESET_INT  = DIV_WIDTH'(2),
  parameter logic [FRAC_WIDTH-1:0] RESET_FRAC = '0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  enable,
  input  logic                  restart,
  input  logic                  adoptReq,
  input  logic [DIV_WIDTH-1:0]  nextInt,
  input  logic [FRAC_WIDTH-1:0] nextFrac,
  output logic                  tick,
  output logic                  wrap_c
);

  logic [DIV_WIDTH-1:0]  count;
  logic [DIV_WIDTH-1:0]  actInt;
  logic [FRAC_WIDTH-1:0] actFrac;
  logic [FRAC_WIDTH-1:0] acc;
  logic                  carry;
  logic                  pendFlag;

  logic [DIV_WIDTH-1:0]  lastCount_c;
  logic [FRAC_WIDTH:0]   accSum_c;
  logic                  adoptNow_c;
  logic                  restartNow_c;

  // Terminal count: period-1, where period is actInt plus the carry from the last wrap.
  always_comb begin
    lastCount_c  = carry ? actInt : actInt - DIV_WIDTH'(1);
    accSum_c     = {1'b0, acc} + {1'b0, actFrac};
    adoptNow_c   = adoptReq | pendFlag;
    restartNow_c = enable & restart;
    wrap_c       = enable & ~restart & (count == lastCount_c);
  end

  // Counter, accumulator, active/pending divisor and tick register.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      count    <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      actInt   <= RESET_INT;
      actFrac  <= RESET_FRAC;
      pendFlag <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;

      // Pending divisor is consumed at a wrap or restart; otherwise a load arms it.
      if (restartNow_c || wrap_c) begin
        if (adoptNow_c) begin
          actInt  <= nextInt;
          actFrac <= nextFrac;
        end
        pendFlag <= 1'b0;
      end else if (adoptReq) begin
        pendFlag <= 1'b1;
      end

      if (restartNow_c) begin
        count <= '0;
        acc   <= '0;
        carry <= 1'b0;
      end else if (wrap_c) begin
        count <= '0;
        acc   <= accSum_c[FRAC_WIDTH-1:0];
        carry <= accSum_c[FRAC_WIDTH];
        tick  <= 1'b1;
      end else if (enable) begin
        count <= count + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/baud_tick_generator.sv
// Programmable UART baud tick generator. Produces single-cycle enables on clk:
// rxTick at OVERSAMPLE x baud with a restartable phase, rxSample at mid-bit,
// and txTick at baud. Divisor loads are validated here and shared by the
// independent rx and tx divider paths.
//
// Ports:
//   clk, rstN   clock, synchronous active-low reset
//   enable      1 = counting; 0 = freeze all state, ticks 0
//   divInt      integer clocks per rx tick (must be >= 2)
//   divFrac     fractional clocks per rx tick, units of 2^-FRAC_WIDTH
//   divLoad     one-cycle strobe capturing divInt/divFrac
//   divErr      one-cycle pulse: load rejected
//   rxRestart   one-cycle strobe restarting the rx phase
//   rxTick      one-cycle pulse at OVERSAMPLE x baud
//   rxPhase     rx tick index within the bit
//   rxSample    one-cycle pulse at mid-bit
//   txTick      one-cycle pulse at baud
module baud_tick_generator
  import uart_pkg::*;
#(
  parameter longint unsigned CLOCK_RATE = 100000000,
  parameter longint unsigned BAUD_RATE  = 9600,
  parameter int unsigned     OVERSAMPLE = 16,
  parameter int unsigned     DIV_WIDTH  = DEF_DIV_WIDTH,
  parameter int unsigned     FRAC_WIDTH = DEF_FRAC_WIDTH
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          divInt,
  input  logic [FRAC_WIDTH-1:0]         divFrac,
  input  logic                          divLoad,
  output logic                          divErr,
  input  logic                          rxRestart,
  output logic                          rxTick,
  output logic [$clog2(OVERSAMPLE)-1:0] rxPhase,
  output logic                          rxSample,
  output logic                          txTick
);

  localparam int unsigned     PH_W     = $clog2(OVERSAMPLE);
  localparam longint unsigned DEF_DIV  = defaultDivisor(CLOCK_RATE, BAUD_RATE,
                                                        longint'(OVERSAMPLE), FRAC_WIDTH);
  localparam longint unsigned DEF_INT  = DEF_DIV >> FRAC_WIDTH;
  localparam logic [DIV_WIDTH-1:0]  DEF_INT_V  = DIV_WIDTH'(DEF_INT);
  localparam logic [FRAC_WIDTH-1:0] DEF_FRAC_V = FRAC_WIDTH'(DEF_DIV);

  if (!oversampleLegal(OVERSAMPLE)) begin : g_badOversample
    $error("OVERSAMPLE must be a power of two in 4..64");
  end

  if ((DEF_INT < 2) || (DEF_INT >= (64'd1 << DIV_WIDTH))) begin : g_badDefault
    $error("default divisor integer part is below 2 or does not fit DIV_WIDTH");
  end

  logic [DIV_WIDTH-1:0]  pendInt;
  logic [FRAC_WIDTH-1:0] pendFrac;
  logic [PH_W-1:0]       txCnt;

  logic                  loadOk_c;
  logic [DIV_WIDTH-1:0]  nextInt_c;
  logic [FRAC_WIDTH-1:0] nextFrac_c;
  logic                  rxWrap_c;
  logic                  txWrap_c;

  // Accepted loads bypass the pending register so a path wrapping or
  // restarting on the load edge picks up the new value directly.
  always_comb begin
    loadOk_c   = divLoad && (divInt >= DIV_WIDTH'(2));
    nextInt_c  = loadOk_c ? divInt  : pendInt;
    nextFrac_c = loadOk_c ? divFrac : pendFrac;
  end

  // Shared pending divisor and load-reject pulse (not gated by enable).
  always_ff @(posedge clk) begin
    if (!rstN) begin
      pendInt  <= DEF_INT_V;
      pendFrac <= DEF_FRAC_V;
      divErr   <= 1'b0;
    end else begin
      divErr <= divLoad && (divInt < DIV_WIDTH'(2));
      if (loadOk_c) begin
        pendInt  <= divInt;
        pendFrac <= divFrac;
      end
    end
  end

  baud_tick_divider #(
    .DIV_WIDTH (DIV_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH),
    .RESET_INT (DEF_INT_V),
    .RESET_FRAC(DEF_FRAC_V)
  ) u_rxDiv (
    .clk     (clk),
    .rstN    (rstN),
    .enable  (enable),
    .restart (rxRestart),
    .adoptReq(loadOk_c),
    .nextInt (nextInt_c),
    .nextFrac(nextFrac_c),
    .tick    (rxTick),
    .wrap_c  (rxWrap_c)
  );

  baud_tick_divider #(
    .DIV_WIDTH (DIV_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH),
    .RESET_INT (DEF_INT_V),
    .RESET_FRAC(DEF_FRAC_V)
  ) u_txDiv (
    .clk     (clk),
    .rstN    (rstN),
    .enable  (enable),
    .restart (1'b0),
    .adoptReq(loadOk_c),
    .nextInt (nextInt_c),
    .nextFrac(nextFrac_c),
    .tick    (),
    .wrap_c  (txWrap_c)
  );

  // rx phase advances with each rx wrap, so rxPhase and rxSample line up with rxTick.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      rxPhase  <= '0;
      rxSample <= 1'b0;
    end else begin
      rxSample <= 1'b0;
      if (enable && rxRestart) begin
        rxPhase <= '0;
      end else if (rxWrap_c) begin
        rxPhase  <= rxPhase + PH_W'(1);
        rxSample <= (rxPhase + PH_W'(1)) == PH_W'(OVERSAMPLE / 2);
      end
    end
  end

  // tx bit = OVERSAMPLE tx-divider periods; txTick marks the wrap of that count.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      txCnt  <= '0;
      txTick <= 1'b0;
    end else begin
      txTick <= txWrap_c && (txCnt == PH_W'(OVERSAMPLE - 1));
      if (txWrap_c) begin
        txCnt <= txCnt + PH_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed and randomized checks of baud_tick_generator against a countdown
// reference model of the tick spacing rules, plus directed period measurements.
module tb_baud_tick_generator;

  localparam int OS      = 16;
  localparam int FW      = 4;
  localparam int DW      = 16;
  localparam int FSCALE  = 1 << FW;
  localparam int DEF_INT = 651;

  logic          clk;
  logic          rstN;
  logic          enable;
  logic [DW-1:0] divInt;
  logic [FW-1:0] divFrac;
  logic          divLoad;
  logic          divErr;
  logic          rxRestart;
  logic          rxTick;
  logic [3:0]    rxPhase;
  logic          rxSample;
  logic          txTick;

  baud_tick_generator dut (
    .clk      (clk),
    .rstN     (rstN),
    .enable   (enable),
    .divInt   (divInt),
    .divFrac  (divFrac),
    .divLoad  (divLoad),
    .divErr   (divErr),
    .rxRestart(rxRestart),
    .rxTick   (rxTick),
    .rxPhase  (rxPhase),
    .rxSample (rxSample),
    .txTick   (txTick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: each path counts down the clocks left in its current period.
  typedef struct {
    int divi;
    int frac;
    int left;
    int acc;
    bit pend;
  } pathT;

  pathT mr, mt;
  int   pInt, pFrac;
  int   mPh, mTx;
  bit   eRxTick, eRxSample, eTxTick, eDivErr;

  function automatic void pathEdge(inout pathT p, input bit rst, input int pi, input int pf,
                                   output bit wrap);
    int s;
    wrap = 1'b0;
    if (rst) begin
      p.acc = 0;
      if (p.pend) begin p.divi = pi; p.frac = pf; p.pend = 0; end
      p.left = p.divi;
    end else begin
      p.left = p.left - 1;
      if (p.left == 0) begin
        wrap  = 1'b1;
        s     = p.acc + p.frac;
        p.acc = s % FSCALE;
        if (p.pend) begin p.divi = pi; p.frac = pf; p.pend = 0; end
        p.left = p.divi + s / FSCALE;
      end
    end
  endfunction

  task automatic modelEdge();
    bit w;
    if (!rstN) begin
      mr = '{divi: DEF_INT, frac: 0, left: DEF_INT, acc: 0, pend: 0};
      mt = mr;
      pInt = DEF_INT; pFrac = 0; mPh = 0; mTx = 0;
      eRxTick = 0; eRxSample = 0; eTxTick = 0; eDivErr = 0;
    end else begin
      eDivErr = divLoad && (int'(divInt) < 2);
      if (divLoad && int'(divInt) >= 2) begin
        pInt = int'(divInt); pFrac = int'(divFrac); mr.pend = 1; mt.pend = 1;
      end
      eRxTick = 0; eRxSample = 0; eTxTick = 0;
      if (enable) begin
        pathEdge(mr, rxRestart, pInt, pFrac, w);
        if (rxRestart) mPh = 0;
        else if (w) begin
          eRxTick = 1; mPh = (mPh + 1) % OS; eRxSample = (mPh == OS / 2);
        end
        pathEdge(mt, 1'b0, pInt, pFrac, w);
        if (w) begin
          mTx = (mTx + 1) % OS; eTxTick = (mTx == 0);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, compare all
  // outputs just after it, then drop the one-cycle strobes.
  task automatic step();
    @(posedge clk);
    modelEdge();
    cyc++;
    #1;
    chk("rxTick",   32'(rxTick),   32'(eRxTick));
    chk("rxSample", 32'(rxSample), 32'(eRxSample));
    chk("txTick",   32'(txTick),   32'(eTxTick));
    chk("divErr",   32'(divErr),   32'(eDivErr));
    chk("rxPhase",  32'(rxPhase),  32'(mPh));
    divLoad   = 1'b0;
    rxRestart = 1'b0;
  endtask

  task automatic waitTick(input bit isTx, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((isTx ? txTick : rxTick) === 1'b1) begin
        t = cyc;
        break;
      end
    end
    chk(isTx ? "txTickTimeout" : "rxTickTimeout", 32'(t >= 0), 32'd1);
  endtask

  initial begin
    int t0, t1, r, n;
    int fracExp[5];
    fracExp = '{4, 4, 5, 4, 5};

    rstN = 1'b0; enable = 1'b0; divInt = '0; divFrac = '0;
    divLoad = 1'b0; rxRestart = 1'b0;
    step();
    step();
    chk("rstRxTick", 32'(rxTick), 32'd0);
    chk("rstTxTick", 32'(txTick), 32'd0);
    chk("rstPhase",  32'(rxPhase), 32'd0);
    chk("rstDivErr", 32'(divErr), 32'd0);

    // Integer divisor 4, rx adopts immediately through the restart.
    rstN = 1'b1; enable = 1'b1;
    divInt = 4; divFrac = 0; divLoad = 1'b1; rxRestart = 1'b1;
    step();
    r = cyc;
    waitTick(1'b0, 20, t1);
    chk("firstRxPeriod", 32'(t1 - r), 32'd4);
    chk("phaseAfterRestart", 32'(rxPhase), 32'd1);
    for (int i = 0; i < 3; i++) begin
      t0 = t1;
      waitTick(1'b0, 20, t1);
      chk("rxPeriod4", 32'(t1 - t0), 32'd4);
    end

    // rxSample coincides with rxPhase becoming OS/2.
    n = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rxSample === 1'b1) begin n = i; break; end
    end
    chk("rxSampleSeen", 32'(n >= 0), 32'd1);
    chk("rxSamplePhase", 32'(rxPhase), 32'd8);

    // tx adopts the load at its own wrap, then runs at 16 x 4 clocks.
    waitTick(1'b1, 1000, t0);
    waitTick(1'b1, 200, t1);
    chk("txPeriod64", 32'(t1 - t0), 32'd64);
    t0 = t1;
    waitTick(1'b1, 200, t1);
    chk("txPeriod64b", 32'(t1 - t0), 32'd64);

    // Fractional divisor 4 + 8/16.
    divInt = 4; divFrac = 8; divLoad = 1'b1; rxRestart = 1'b1;
    step();
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      waitTick(1'b0, 20, t1);
      chk("fracPeriod", 32'(t1 - t0), 32'(fracExp[i]));
      t0 = t1;
    end

    // Divisor change 4 -> 10 mid-period: current period finishes at 4.
    divInt = 4; divFrac = 0; divLoad = 1'b1; rxRestart = 1'b1;
    step();
    waitTick(1'b0, 20, t0);
    step();
    divInt = 10; divLoad = 1'b1;
    step();
    waitTick(1'b0, 20, t1);
    chk("midChangeOld", 32'(t1 - t0), 32'd4);
    for (int i = 0; i < 2; i++) begin
      t0 = t1;
      waitTick(1'b0, 20, t1);
      chk("midChangeNew", 32'(t1 - t0), 32'd10);
    end

    // Rejected load: divErr pulses once, spacing unchanged.
    divInt = 1; divLoad = 1'b1;
    step();
    chk("divErrPulse", 32'(divErr), 32'd1);
    step();
    chk("divErrClear", 32'(divErr), 32'd0);
    t0 = t1;
    waitTick(1'b0, 20, t1);
    chk("rejectKeepsPeriod", 32'(t1 - t0), 32'd10);

    // Restart at an arbitrary point in the period.
    n = int'($urandom_range(1, 8));
    for (int i = 0; i < n; i++) step();
    rxRestart = 1'b1;
    step();
    r = cyc;
    waitTick(1'b0, 20, t1);
    chk("restartPeriod", 32'(t1 - r), 32'd10);
    chk("restartPhase", 32'(rxPhase), 32'd1);

    // enable low for 7 clocks mid-period stretches that period by 7.
    waitTick(1'b0, 20, t0);
    for (int i = 0; i < 3; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 7; i++) step();
    enable = 1'b1;
    waitTick(1'b0, 40, t1);
    chk("enableStretch", 32'(t1 - t0), 32'd17);

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      divLoad   = ($urandom_range(0, 39) == 0);
      divInt    = DW'($urandom_range(0, 12));
      divFrac   = FW'($urandom_range(0, FSCALE - 1));
      rxRestart = ($urandom_range(0, 49) == 0);
      step();
    end

    // Reset mid-period returns to the default divisor.
    enable = 1'b1;
    divInt = 7; divLoad = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    rstN = 1'b0;
    step();
    r = cyc;
    chk("midRstRxTick",   32'(rxTick),   32'd0);
    chk("midRstTxTick",   32'(txTick),   32'd0);
    chk("midRstSample",   32'(rxSample), 32'd0);
    chk("midRstPhase",    32'(rxPhase),  32'd0);
    rstN = 1'b1;
    waitTick(1'b0, 700, t1);
    chk("defaultPeriod", 32'(t1 - r), 32'(DEF_INT));
    t0 = t1;
    waitTick(1'b0, 700, t1);
    chk("defaultPeriod2", 32'(t1 - t0), 32'(DEF_INT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
